mips_fifosync_ext: RTL and testbench

Parametrised synchronous FIFO, the next generation of the core's basic FIFO.
- Adds occupancy level, programmable almost-full/almost-empty thresholds, synchronous flush, protected push/pop, and sticky overflow/underflow error flags.
- Adds a selectable output mode: show-ahead (combinational) or registered.
- Used between pipeline stages and the bus interface wherever back-pressure or early warning is needed.
- Single clock domain.

---
 rtl/mips_fifosync_ram.sv | 26 ++
 rtl/mips_fifosync_ext.sv | 124 ++++++++++++
 tb/tb_mips_fifosync_ext.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mips_fifosync_ram.sv
// Storage array for the synchronous FIFOs: one write port and an asynchronous read address.
// The array has no reset. Consumers must qualify the read data themselves.
module mips_fifosync_ram #(
  parameter int S_WORD      = 8,
  parameter int SPOWER2_MEM = 4,
  parameter int AW          = (SPOWER2_MEM > 0) ? SPOWER2_MEM : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [S_WORD-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [S_WORD-1:0] rd_data
);

  localparam int S_MEM = 1 << SPOWER2_MEM;

  logic [S_WORD-1:0] mem [S_MEM];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mips_fifosync_ext.sv
// Synchronous FIFO with occupancy level, almost-full/almost-empty thresholds, flush,
// sticky overflow/underflow flags, and a choice of show-ahead or registered output.
module mips_fifosync_ext #(
  parameter int S_WORD      = 8,
  parameter int SPOWER2_MEM = 4,
  parameter int AFULL_LVL   = (1 << SPOWER2_MEM) - 1,
  parameter int AEMPTY_LVL  = 1,
  parameter int REG_OUT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [S_WORD-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [S_WORD-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [SPOWER2_MEM:0]   level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int S_MEM = 1 << SPOWER2_MEM;
  localparam int PW    = SPOWER2_MEM + 1;
  localparam int AW    = (SPOWER2_MEM > 0) ? SPOWER2_MEM : 1;

  if (AFULL_LVL < 1 || AFULL_LVL > S_MEM) begin : g_bad_afull
    $error("mips_fifosync_ext: AFULL_LVL must lie in 1..S_MEM");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > S_MEM - 1) begin : g_bad_aempty
    $error("mips_fifosync_ext: AEMPTY_LVL must lie in 0..S_MEM-1");
  end

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;
  logic              ram_we;
  logic [S_WORD-1:0] ram_rd_data;

  // Low pointer bits address the array; the mask keeps a depth-1 FIFO at address 0.
  function automatic logic [AW-1:0] mem_addr(input logic [PW-1:0] ptr);
    return AW'(ptr) & AW'(S_MEM - 1);
  endfunction

  assign full    = (wr_ptr ^ rd_ptr) == PW'(S_MEM);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | pop_ok);
  assign ram_we  = push_ok & ~rst & ~flush;

  assign fifo_full    = full;
  assign fifo_empty   = empty;
  assign almost_full  = (level >= PW'(AFULL_LVL));
  assign almost_empty = (level <= PW'(AEMPTY_LVL));

  mips_fifosync_ram #(
    .S_WORD      (S_WORD),
    .SPOWER2_MEM (SPOWER2_MEM),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (mem_addr(wr_ptr)),
    .wr_data (wr_data),
    .rd_addr (mem_addr(rd_ptr)),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
      if (wr_en && full && !pop_ok) overflow  <= 1'b1;
      if (rd_en && empty)           underflow <= 1'b1;
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [S_WORD-1:0] rd_data_q;
    logic              rd_valid_q;

    // Flush drops a pending read but keeps the last data word.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (flush) begin
        rd_valid_q <= 1'b0;
      end else if (pop_ok) begin
        rd_data_q  <= ram_rd_data;
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_show_ahead
    assign rd_data  = ram_rd_data;
    assign rd_valid = ~empty;
  end

  level_tracks_ptrs: assert property (@(posedge clk) disable iff (rst) level == wr_ptr - rd_ptr);

endmodule

// File: tb/tb_mips_fifosync_ext.sv
// Bench for mips_fifosync_ext at depth 4: a show-ahead and a registered instance share the
// same stimulus and are compared against a queue model plus a table of fixed expectations.
module tb_mips_fifosync_ext;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] wr_data;

  logic [7:0] s_rd_data, r_rd_data;
  logic       s_rd_valid, r_rd_valid, s_full, r_full, s_empty, r_empty;
  logic       s_af, r_af, s_ae, r_ae, s_ovf, r_ovf, s_unf, r_unf;
  logic [2:0] s_level, r_level;

  always #5 clk = ~clk;

  mips_fifosync_ext #(.S_WORD(8), .SPOWER2_MEM(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .REG_OUT(0)) u_show (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .fifo_full(s_full), .fifo_empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level), .overflow(s_ovf), .underflow(s_unf));

  mips_fifosync_ext #(.S_WORD(8), .SPOWER2_MEM(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .REG_OUT(1)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .fifo_full(r_full), .fifo_empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .level(r_level), .overflow(r_ovf), .underflow(r_unf));

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  typedef struct {
    bit          f;
    bit          we;
    logic [7:0]  wd;
    bit          re;
    int unsigned lvl;
    logic [7:0]  front;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int unsigned n;
    n = q.size();
    chk("level_sa",     s_level, n);
    chk("level_reg",    r_level, n);
    chk("full",         s_full, (n == 4) ? 1 : 0);
    chk("full_reg",     r_full, (n == 4) ? 1 : 0);
    chk("empty",        s_empty, (n == 0) ? 1 : 0);
    chk("empty_reg",    r_empty, (n == 0) ? 1 : 0);
    chk("almost_full",  s_af, (n >= 3) ? 1 : 0);
    chk("almost_empty", s_ae, (n <= 1) ? 1 : 0);
    chk("afull_reg",    r_af, (n >= 3) ? 1 : 0);
    chk("aempty_reg",   r_ae, (n <= 1) ? 1 : 0);
    chk("overflow",     s_ovf, m_ovf);
    chk("underflow",    s_unf, m_unf);
    chk("overflow_reg", r_ovf, m_ovf);
    chk("underflow_reg", r_unf, m_unf);
    chk("rd_valid_sa",  s_rd_valid, (n != 0) ? 1 : 0);
    if (n != 0) chk("rd_data_sa", s_rd_data, q[0]);
    chk("rd_valid_reg", r_rd_valid, m_rv);
    if (m_rv) chk("rd_data_reg", r_rd_data, m_rd);
  endtask

  task automatic cycle(input bit r, input bit f, input bit we, input logic [7:0] wd, input bit re);
    bit pop_ok, push_ok, was_full, was_empty;
    rst = r; flush = f; wr_en = we; wr_data = wd; rd_en = re;
    was_full  = (q.size() == 4);
    was_empty = (q.size() == 0);
    if (r) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'h00;
    end else if (f) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rv = 0;
    end else begin
      pop_ok  = re && !was_empty;
      push_ok = we && (!was_full || pop_ok);
      if (we && was_full && !pop_ok) m_ovf = 1;
      if (re && was_empty)           m_unf = 1;
      m_rv = pop_ok;
      if (pop_ok)  m_rd = q.pop_front();
      if (push_ok) q.push_back(wd);
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    // {flush, wr_en, wr_data, rd_en, level, front, overflow, underflow} after each edge
    tbl[0]  = '{0, 1, 8'h11, 0, 1, 8'h11, 0, 0};
    tbl[1]  = '{0, 1, 8'h22, 0, 2, 8'h11, 0, 0};
    tbl[2]  = '{0, 1, 8'h33, 0, 3, 8'h11, 0, 0};
    tbl[3]  = '{0, 1, 8'h44, 0, 4, 8'h11, 0, 0};
    tbl[4]  = '{0, 1, 8'h55, 0, 4, 8'h11, 1, 0};
    tbl[5]  = '{0, 1, 8'h55, 1, 4, 8'h22, 1, 0};
    tbl[6]  = '{0, 0, 8'h00, 1, 3, 8'h33, 1, 0};
    tbl[7]  = '{0, 0, 8'h00, 1, 2, 8'h44, 1, 0};
    tbl[8]  = '{0, 0, 8'h00, 1, 1, 8'h55, 1, 0};
    tbl[9]  = '{0, 0, 8'h00, 1, 0, 8'h00, 1, 0};
    tbl[10] = '{0, 1, 8'hA5, 1, 1, 8'hA5, 1, 1};
    tbl[11] = '{0, 1, 8'h01, 0, 2, 8'hA5, 1, 1};
    tbl[12] = '{0, 1, 8'h02, 0, 3, 8'hA5, 1, 1};
    tbl[13] = '{0, 1, 8'h03, 0, 4, 8'hA5, 1, 1};
    tbl[14] = '{0, 1, 8'h04, 0, 4, 8'hA5, 1, 1};
    tbl[15] = '{0, 0, 8'h00, 1, 3, 8'h01, 1, 1};
    tbl[16] = '{1, 1, 8'hEE, 1, 0, 8'h00, 0, 0};
    tbl[17] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0};

    // Reset with a push request pending; the push must be ignored.
    cycle(1, 0, 1, 8'hC3, 1);
    cycle(1, 1, 1, 8'hC3, 0);
    chk("rd_data_reg_rst", r_rd_data, 8'h00);

    for (int i = 0; i < 18; i++) begin
      cycle(0, tbl[i].f, tbl[i].we, tbl[i].wd, tbl[i].re);
      chk("tbl_level", s_level, tbl[i].lvl);
      if (tbl[i].lvl != 0) chk("tbl_front", s_rd_data, tbl[i].front);
      chk("tbl_overflow", s_ovf, tbl[i].ovf);
      chk("tbl_underflow", s_unf, tbl[i].unf);
      if (i == 5) chk("tbl_reg_pop_full", r_rd_data, 8'h11);
    end

    // Pointer wrap with two entries resident.
    cycle(1, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'hAA, 0);
    cycle(0, 0, 1, 8'hBB, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 8'(8'h60 + i), 1);
      chk("wrap_level", s_level, 2);
    end
    chk("wrap_front", s_rd_data, 8'h68);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 97) == 0, ($urandom % 37) == 0, $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
